johnson_counter_param: RTL and testbench
========================================

# johnson_counter_param

Parametrised synchronous Johnson (twisted-ring) counter, the successor to the fixed 4-bit down-only counter. It has configurable width, a runtime up/down direction, count enable, validated parallel load, a decoded phase index and a wrap pulse. It sits in the sequencing logic as a glitch-free phase generator, and its decoded phase feeds downstream state decoders directly.

## Interface
- WIDTH, 4: number of flip-flops; sequence length is 2*WIDTH states; legal range WIDTH >= 2.
- PW, $clog2(2*WIDTH): width of the phase index (derived; not overridden).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; the counter advances one state per clk while high.
- dir  in  1  direction: 0 = up (shift left), 1 = down (shift right).
- load  in  1  synchronous parallel load request; has priority over en.
- load_val  in  WIDTH  value to load; accepted only if it is a legal Johnson code.
- q  out  WIDTH  counter state (registered).
- phase  out  PW  index of q in the up sequence, 0..2*WIDTH-1 (registered).
- wrap  out  1  one-cycle pulse, registered; high in the cycle q has just entered all-zeros by counting.
- load_err  out  1  one-cycle pulse, registered; high in the cycle after an illegal load_val was rejected.

## Operation
- Up step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
- Down step: q <= {~q[0], q[WIDTH-1:1]}.
- Phase numbering:
  - all-zeros = 0.
  - k trailing ones (k = 1..WIDTH) = k.
  - all-ones with k low zeros (k = 1..WIDTH-1) = WIDTH+k.
  - Example, WIDTH=4: 1000 = 7.
- Phase steps with q:
  - Up: phase <= (phase == 2*WIDTH-1) ? 0 : phase+1.
  - Down: phase <= (phase == 0) ? 2*WIDTH-1 : phase-1.
  - phase is kept as its own register, updated alongside q; it is not decoded combinationally from q.
- Legal code: q has at most one 0/1 boundary between adjacent bits, i.e. the form 0..01..1 or 1..10..0. Exactly 2*WIDTH legal codes exist.
- Priority per edge, highest first:
  1. rst.
  2. load.
  3. en.
  4. hold.
- load=1 with a legal load_val:
  - q <= load_val; phase <= its index.
  - wrap <= 0, even if load_val is all-zeros.
  - load_err <= 0.
  - en and dir are ignored that cycle.
- load=1 with an illegal load_val:
  - q and phase hold; load_err <= 1; wrap <= 0.
  - Counting is also suppressed that cycle.
- en=1, load=0: step in the direction given by dir; wrap <= (next q == 0); load_err <= 0.
- en=0, load=0: q and phase hold; wrap <= 0; load_err <= 0.
- dir may change on any cycle. The new direction takes effect on the next enabled edge with no lost or repeated state beyond the reversal itself.

## Timing
- Reset, asynchronous: outputs take these values immediately on rst rising, without waiting for clk:
  - q = all ones.
  - phase = WIDTH.
  - wrap = 0.
  - load_err = 0.
- Reset mid-operation: an in-flight load or count is discarded. The first step occurs on the first rising clk edge where rst is low.
- Latency is 1 cycle: en/load/dir sampled at edge n are reflected on q, phase, wrap and load_err after edge n.
- All outputs are registered; q changes exactly one bit per step, so it is glitch-free.
- wrap and load_err are single-cycle pulses. Repeated qualifying events on consecutive cycles give consecutive pulses; no stretching.
- Wrap-around needs no special case: up from phase 2*WIDTH-1 goes to 0 with wrap=1, and down from phase 1 goes to 0 with wrap=1.

## Test plan
- Reset: WIDTH=4; assert rst between clk edges while en=1 mid-count -> q=1111, phase=4, wrap=0, load_err=0 immediately, before the next edge.
- Up count: en=1, dir=0 for 9 edges from reset -> q = 1110, 1100, 1000, 0000, 0001, 0011, 0111, 1111, 1110; phase = 5, 6, 7, 0, 1, 2, 3, 4, 5; wrap=1 only after edge 4.
- Down count: en=1, dir=1 from reset for 5 edges -> q = 0111, 0011, 0001, 0000, 1000; phase = 3, 2, 1, 0, 7; wrap=1 only after edge 4.
- Load legal: load=1 with load_val=0011 and en=1 -> q=0011, phase=2, load_err=0. Then load 0000 -> q=0000, phase=0, wrap=0.
- Load illegal: at q=1100, load=1 with load_val=0101 and en=1 -> q stays 1100, phase stays 6, load_err=1 for exactly one cycle; the next load-free edge with en=1 counts normally.
- Hold and reversal: at q=1100, en=0 for 3 edges -> unchanged. Then en=1 with dir flipped 0->1 -> q=1110 (phase 5), then 1111 (phase 4). Repeat all scenarios with WIDTH=5 and confirm a 10-state cycle.

Source files
------------

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with up/down, enable,
// validated parallel load, registered phase index and wrap pulse.
module johnson_counter_param #(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [PW-1:0] LAST = PW'(2*WIDTH-1);
  localparam logic [PW-1:0] MID  = PW'(WIDTH);

  logic [WIDTH-2:0] bnd;
  logic [PW:0]      ones;
  logic             legal;
  logic [PW-1:0]    lv_phase;

  logic [WIDTH-1:0] q_nxt;
  logic [PW-1:0]    phase_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  // Legal codes have at most one boundary between adjacent bits.
  always_comb begin
    bnd   = load_val[WIDTH-1:1] ^ load_val[WIDTH-2:0];
    legal = (bnd & (bnd - 1'b1)) == '0;
    ones  = '0;
    for (int i = 0; i < WIDTH; i++)
      ones = ones + (PW+1)'(load_val[i]);
    if (load_val[0])
      lv_phase = PW'(ones);
    else if (ones == '0)
      lv_phase = '0;
    else
      lv_phase = PW'((PW+1)'(2*WIDTH) - ones);
  end

  always_comb begin
    q_nxt     = q;
    phase_nxt = phase;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      if (legal) begin
        q_nxt     = load_val;
        phase_nxt = lv_phase;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (dir) begin
        q_nxt     = {~q[0], q[WIDTH-1:1]};
        phase_nxt = (phase == '0) ? LAST : phase - 1'b1;
      end else begin
        q_nxt     = {q[WIDTH-2:0], ~q[WIDTH-1]};
        phase_nxt = (phase == LAST) ? '0 : phase + 1'b1;
      end
      wrap_nxt = (q_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '1;
      phase    <= MID;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      phase    <= phase_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Bench for johnson_counter_param: WIDTH=4 and WIDTH=5 instances driven
// in lockstep against a phase-index model.
module tb_johnson_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, dir, load;
  logic [7:0] lv;

  logic [3:0] q4;
  logic [2:0] ph4;
  logic       wr4, le4;
  logic [4:0] q5;
  logic [3:0] ph5;
  logic       wr5, le5;

  int checks   = 0;
  int failures = 0;

  int wd[2] = '{4, 5};
  int mph[2];
  bit mwr[2];
  bit mle[2];

  always #5 clk = ~clk;

  johnson_counter_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv[3:0]), .q(q4), .phase(ph4),
    .wrap(wr4), .load_err(le4)
  );

  johnson_counter_param #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv[4:0]), .q(q5), .phase(ph5),
    .wrap(wr5), .load_err(le5)
  );

  // Johnson code of phase p for width w, straight from the numbering rule.
  function automatic logic [7:0] code(int w, int p);
    logic [7:0] v = '0;
    if (p <= w) begin
      for (int i = 0; i < p; i++) v[i] = 1'b1;
    end else begin
      for (int i = p - w; i < w; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic int idx(int w, logic [7:0] v);
    for (int p = 0; p < 2*w; p++)
      if (code(w, p) == v) return p;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] oq, op, ow, oe;
    for (int k = 0; k < 2; k++) begin
      oq = k ? 32'(q5)  : 32'(q4);
      op = k ? 32'(ph5) : 32'(ph4);
      ow = k ? 32'(wr5) : 32'(wr4);
      oe = k ? 32'(le5) : 32'(le4);
      chk($sformatf("%s.w%0d.q", tag, wd[k]), oq, 32'(code(wd[k], mph[k])));
      chk($sformatf("%s.w%0d.phase", tag, wd[k]), op, 32'(mph[k]));
      chk($sformatf("%s.w%0d.wrap", tag, wd[k]), ow, 32'(mwr[k]));
      chk($sformatf("%s.w%0d.load_err", tag, wd[k]), oe, 32'(mle[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mph[k] = wd[k];
      mwr[k] = 1'b0;
      mle[k] = 1'b0;
    end
  endtask

  task automatic model_step(bit e, bit d, bit l, logic [7:0] v);
    int n, p;
    logic [7:0] m;
    for (int k = 0; k < 2; k++) begin
      n = 2*wd[k];
      m = 8'((1 << wd[k]) - 1);
      if (l) begin
        p = idx(wd[k], v & m);
        if (p >= 0) begin
          mph[k] = p;
          mle[k] = 1'b0;
        end else begin
          mle[k] = 1'b1;
        end
        mwr[k] = 1'b0;
      end else if (e) begin
        mph[k] = d ? (mph[k] + n - 1) % n : (mph[k] + 1) % n;
        mwr[k] = (mph[k] == 0);
        mle[k] = 1'b0;
      end else begin
        mwr[k] = 1'b0;
        mle[k] = 1'b0;
      end
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled there too.
  task automatic step(string tag, bit e, bit d, bit l, logic [7:0] v);
    en   = e;
    dir  = d;
    load = l;
    lv   = v;
    @(posedge clk);
    #1;
    model_step(e, d, l, v);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rv;
    bit re, rd, rl;
    rst  = 1'b1;
    en   = 1'b0;
    dir  = 1'b0;
    load = 1'b0;
    lv   = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) step($sformatf("up%0d", i), 1, 0, 0, 0);

    en = 1'b1;
    step("pre_rst", 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step($sformatf("dn%0d", i), 1, 1, 0, 0);

    step("ld_legal", 1, 0, 1, 8'h03);
    step("ld_zero", 1, 0, 1, 8'h00);

    step("ld_p6", 0, 0, 1, 8'h0C);
    step("ld_ill", 1, 0, 1, 8'h05);
    step("ld_ill2", 1, 1, 1, 8'h09);
    step("after_ill", 1, 0, 0, 0);

    step("ld_p6b", 0, 0, 1, 8'h0C);
    for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 0, 0, 0, 0);
    step("rev0", 1, 1, 0, 0);
    step("rev1", 1, 1, 0, 0);

    for (int i = 0; i < 10; i++) step($sformatf("cyc%0d", i), 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step($sformatf("dcyc%0d", i), 1, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      re = ($urandom_range(0, 3) != 0);
      rd = $urandom_range(0, 1) != 0;
      rl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) != 0)
        rv = code(4, $urandom_range(0, 7));
      else
        rv = 8'($urandom);
      step($sformatf("rnd%0d", i), re, rd, rl, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
